// File: rtl/maze_reader_if.sv
`timescale 1ns/1ps
// maze_reader_if
//   Cell stream from the maze reader to its consumers (tile renderer, solver).
//   One beat per cell, valid/ready handshake; a beat transfers on a rising
//   clock edge where cell_valid and cell_ready are both high.
//
//   cell_valid  master->slave  beat valid
//   cell_ready  slave->master  consumer accepts the beat
//   cell_x      master->slave  column of the beat
//   cell_y      master->slave  row of the beat
//   cell_code   master->slave  00 OUT, 01 FRONTIER, 10 WALL, 11 PATH
//   cell_solid  master->slave  1 for OUT or WALL (impassable)
//   cell_last   master->slave  final beat of the scan window
interface maze_reader_if #(
  parameter int XW = 6,
  parameter int YW = 6,
  parameter int CW = 2
);
  logic          cell_valid;
  logic          cell_ready;
  logic [XW-1:0] cell_x;
  logic [YW-1:0] cell_y;
  logic [CW-1:0] cell_code;
  logic          cell_solid;
  logic          cell_last;

  modport master (
    output cell_valid, cell_x, cell_y, cell_code, cell_solid, cell_last,
    input  cell_ready
  );

  modport slave (
    input  cell_valid, cell_x, cell_y, cell_code, cell_solid, cell_last,
    output cell_ready
  );
endinterface

// File: rtl/maze_reader.sv
`timescale 1ns/1ps
// maze_reader
//   Streams the cells of the carver's packed maze bitmap in raster order
//   (x fastest) inside a win_w x win_h window anchored at (0,0), and counts
//   the PATH cells that the consumer accepts. Never writes maze_data.
//
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   maze_data    packed bitmap, cell (x,y) at [(y*COLS+x)*CELL_W +: CELL_W]
//   maze_done    carver finished (level); required for a scan to start
//   start        scan request, looked at in IDLE only
//   abort        cancels a scan in LOAD/SCAN, wins over a same-cycle handshake
//   win_w/win_h  window size in cells; 0 or oversize means full width/height
//   cell_if      master side of the cell stream
//   busy         high in LOAD and SCAN
//   done         one-cycle pulse after the last beat is accepted
//   path_count   PATH beats accepted in the current/last scan
//   start_err    sticky: start seen while maze_done was low
module maze_reader #(
  parameter int COLS   = 64,
  parameter int ROWS   = 64,
  parameter int CELL_W = 2
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [COLS*ROWS*CELL_W-1:0]         maze_data,
  input  logic                                maze_done,
  input  logic                                start,
  input  logic                                abort,
  input  logic [$clog2(COLS):0]               win_w,
  input  logic [$clog2(ROWS):0]               win_h,
  maze_reader_if.master                       cell_if,
  output logic                                busy,
  output logic                                done,
  output logic [$clog2(COLS*ROWS):0]          path_count,
  output logic                                start_err
);

  localparam int XW  = $clog2(COLS);
  localparam int YW  = $clog2(ROWS);
  localparam int PCW = $clog2(COLS*ROWS) + 1;
  localparam int AW  = $clog2(COLS*ROWS*CELL_W);

  localparam logic [XW:0]    COLS_W = COLS[XW:0];
  localparam logic [YW:0]    ROWS_H = ROWS[YW:0];
  localparam logic [XW:0]    W_ONE  = 1;
  localparam logic [YW:0]    H_ONE  = 1;
  localparam logic [XW-1:0]  X_ONE  = 1;
  localparam logic [YW-1:0]  Y_ONE  = 1;
  localparam logic [PCW-1:0] PC_ONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [XW-1:0]   x_reg, x_next;
  logic [YW-1:0]   y_reg, y_next;
  // Window stored as index of its last column/row so end tests are plain compares.
  logic [XW-1:0]   lastx_reg, lastx_next;
  logic [YW-1:0]   lasty_reg, lasty_next;
  logic            valid_reg, valid_next;
  logic [XW-1:0]   cx_reg, cx_next;
  logic [YW-1:0]   cy_reg, cy_next;
  logic [CELL_W-1:0] code_reg, code_next;
  logic            solid_reg, solid_next;
  logic            last_reg, last_next;
  logic [PCW-1:0]  path_count_reg, path_count_next;
  logic            start_err_reg, start_err_next;

  logic [XW:0]     win_w_clamped;
  logic [YW:0]     win_h_clamped;
  logic [XW:0]     win_w_m1;
  logic [YW:0]     win_h_m1;

  logic            x_end;
  logic [XW-1:0]   adv_x, sel_x;
  logic [YW-1:0]   adv_y, sel_y;
  logic [AW-1:0]   fetch_idx;
  logic [CELL_W-1:0] fetch_code;
  logic            fetch_last;
  logic            handshake;

  // Window clamp: zero or oversize selects the full maze dimension.
  always_comb begin
    win_w_clamped = win_w;
    if (win_w == '0 || win_w > COLS_W) win_w_clamped = COLS_W;
    win_h_clamped = win_h;
    if (win_h == '0 || win_h > ROWS_H) win_h_clamped = ROWS_H;
    win_w_m1 = win_w_clamped - W_ONE;
    win_h_m1 = win_h_clamped - H_ONE;
  end

  // Cell fetch. LOAD presents the pointer itself; SCAN presents the cell
  // after the pointer so it can be registered on the accepting edge.
  always_comb begin
    x_end = (x_reg == lastx_reg);
    adv_x = x_end ? '0 : x_reg + X_ONE;
    adv_y = x_end ? y_reg + Y_ONE : y_reg;
    sel_x = (state_reg == SCAN) ? adv_x : x_reg;
    sel_y = (state_reg == SCAN) ? adv_y : y_reg;
    fetch_idx  = (AW'(sel_y) * AW'(COLS) + AW'(sel_x)) * AW'(CELL_W);
    fetch_code = maze_data[fetch_idx +: CELL_W];
    fetch_last = (sel_x == lastx_reg) && (sel_y == lasty_reg);
  end

  assign handshake = valid_reg && cell_if.cell_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      x_reg          <= '0;
      y_reg          <= '0;
      lastx_reg      <= '0;
      lasty_reg      <= '0;
      valid_reg      <= 1'b0;
      cx_reg         <= '0;
      cy_reg         <= '0;
      code_reg       <= '0;
      solid_reg      <= 1'b0;
      last_reg       <= 1'b0;
      path_count_reg <= '0;
      start_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      lastx_reg      <= lastx_next;
      lasty_reg      <= lasty_next;
      valid_reg      <= valid_next;
      cx_reg         <= cx_next;
      cy_reg         <= cy_next;
      code_reg       <= code_next;
      solid_reg      <= solid_next;
      last_reg       <= last_next;
      path_count_reg <= path_count_next;
      start_err_reg  <= start_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    x_next          = x_reg;
    y_next          = y_reg;
    lastx_next      = lastx_reg;
    lasty_next      = lasty_reg;
    valid_next      = valid_reg;
    cx_next         = cx_reg;
    cy_next         = cy_reg;
    code_next       = code_reg;
    solid_next      = solid_reg;
    last_next       = last_reg;
    path_count_next = path_count_reg;
    start_err_next  = start_err_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (maze_done) begin
            lastx_next      = win_w_m1[XW-1:0];
            lasty_next      = win_h_m1[YW-1:0];
            x_next          = '0;
            y_next          = '0;
            path_count_next = '0;
            start_err_next  = 1'b0;
            state_next      = LOAD;
          end else begin
            start_err_next  = 1'b1;
          end
        end
      end

      LOAD: begin
        if (abort) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          state_next = IDLE;
        end else begin
          cx_next    = sel_x;
          cy_next    = sel_y;
          code_next  = fetch_code;
          solid_next = ~fetch_code[0];
          last_next  = fetch_last;
          valid_next = 1'b1;
          state_next = SCAN;
        end
      end

      SCAN: begin
        if (abort) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          state_next = IDLE;
        end else if (handshake) begin
          if (&code_reg) path_count_next = path_count_reg + PC_ONE;
          if (last_reg) begin
            valid_next = 1'b0;
            last_next  = 1'b0;
            state_next = FIN;
          end else begin
            // Register the following cell on the accepting edge so that a
            // consumer holding ready high receives one beat per cycle.
            x_next     = adv_x;
            y_next     = adv_y;
            cx_next    = sel_x;
            cy_next    = sel_y;
            code_next  = fetch_code;
            solid_next = ~fetch_code[0];
            last_next  = fetch_last;
          end
        end
      end

      FIN: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign cell_if.cell_valid = valid_reg;
  assign cell_if.cell_x     = cx_reg;
  assign cell_if.cell_y     = cy_reg;
  assign cell_if.cell_code  = code_reg;
  assign cell_if.cell_solid = solid_reg;
  assign cell_if.cell_last  = last_reg;

  assign busy       = (state_reg == LOAD) || (state_reg == SCAN);
  assign done       = (state_reg == FIN);
  assign path_count = path_count_reg;
  assign start_err  = start_err_reg;

endmodule

// File: tb/tb_maze_reader.sv
`timescale 1ns/1ps
module tb_maze_reader;

  logic          clk;
  logic          reset_n;
  logic [8191:0] maze_data;
  logic          maze_done;
  logic          start;
  logic          abort;
  logic [6:0]    win_w;
  logic [6:0]    win_h;
  logic          busy;
  logic          done;
  logic [12:0]   path_count;
  logic          start_err;

  maze_reader_if cell_if ();

  maze_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .maze_data  (maze_data),
    .maze_done  (maze_done),
    .start      (start),
    .abort      (abort),
    .win_w      (win_w),
    .win_h      (win_h),
    .cell_if    (cell_if),
    .busy       (busy),
    .done       (done),
    .path_count (path_count),
    .start_err  (start_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int total = 0;
  int bad   = 0;

  int bx [4096];
  int by [4096];
  int bc [4096];
  int bs [4096];
  int bl [4096];
  int bcyc [4096];
  int nbeat;
  int nlast;
  int done_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("check %s got=%0d ok", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cell(input int x, input int y, input logic [1:0] code);
    maze_data[(y*64 + x)*2 +: 2] = code;
  endtask

  // Pulse start and check LOAD timing: busy after one edge, first beat after two.
  task automatic kick(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_load_valid"}, cell_if.cell_valid, 1'b0);
    chk({tag, "_load_busy"}, busy, 1'b1);
    step();
    chk({tag, "_first_valid"}, cell_if.cell_valid, 1'b1);
  endtask

  // Consume beats until done; optional stall of stall_len cycles on beat stall_at.
  task automatic collect(input int limit, input int stall_at, input int stall_len);
    logic stall_pending;
    int hx, hy, hc;
    nbeat = 0;
    nlast = 0;
    done_cyc = -1;
    stall_pending = (stall_at >= 0);
    for (int i = 0; i < limit; i++) begin
      if (cell_if.cell_valid && stall_pending && nbeat == stall_at) begin
        stall_pending = 1'b0;
        hx = int'(cell_if.cell_x);
        hy = int'(cell_if.cell_y);
        hc = int'(cell_if.cell_code);
        cell_if.cell_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          step();
          chk("stall_valid", cell_if.cell_valid, 1'b1);
          chk("stall_x", cell_if.cell_x, hx);
          chk("stall_y", cell_if.cell_y, hy);
          chk("stall_code", cell_if.cell_code, hc);
        end
        cell_if.cell_ready = 1'b1;
      end
      if (cell_if.cell_valid && cell_if.cell_ready && nbeat < 4096) begin
        bx[nbeat]   = int'(cell_if.cell_x);
        by[nbeat]   = int'(cell_if.cell_y);
        bc[nbeat]   = int'(cell_if.cell_code);
        bs[nbeat]   = int'(cell_if.cell_solid);
        bl[nbeat]   = int'(cell_if.cell_last);
        bcyc[nbeat] = cyc_cnt;
        if (cell_if.cell_last) nlast++;
        nbeat++;
      end
      if (done) begin
        done_cyc = cyc_cnt;
        break;
      end
      step();
    end
    if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int exp_x [6] = '{0, 1, 2, 0, 1, 2};
  int exp_y [6] = '{0, 0, 0, 1, 1, 1};
  int exp_c [6] = '{0, 3, 0, 0, 0, 3};

  initial begin
    reset_n = 1'b0;
    maze_data = '0;
    maze_done = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    win_w = 7'd0;
    win_h = 7'd0;
    cell_if.cell_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_valid", cell_if.cell_valid, 1'b0);
    chk("rst_last", cell_if.cell_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", start_err, 1'b0);
    chk("rst_xy", {cell_if.cell_x, cell_if.cell_y}, 12'd0);
    chk("rst_code", cell_if.cell_code, 2'd0);
    chk("rst_solid", cell_if.cell_solid, 1'b0);
    chk("rst_pc", path_count, 13'd0);
    reset_n = 1'b1;
    step();

    // Full 64x64 scan, window 0x0
    maze_data = '0;
    set_cell(0, 0, 2'b11);
    set_cell(63, 63, 2'b10);
    maze_done = 1'b1;
    kick("full");
    collect(5000, -1, 0);
    chk("full_beats", nbeat, 4096);
    chk("full_b1_x", bx[0], 0);
    chk("full_b1_y", by[0], 0);
    chk("full_b1_code", bc[0], 3);
    chk("full_b1_solid", bs[0], 0);
    chk("full_bn_x", bx[4095], 63);
    chk("full_bn_y", by[4095], 63);
    chk("full_bn_code", bc[4095], 2);
    chk("full_bn_solid", bs[4095], 1);
    chk("full_bn_last", bl[4095], 1);
    chk("full_nlast", nlast, 1);
    chk("full_b2_x", bx[1], 1);
    chk("full_b65_y", by[64], 1);
    chk("full_b65_x", bx[64], 0);
    chk("full_back2back", bcyc[4095] - bcyc[0], 4095);
    chk("full_done_lat", done_cyc - bcyc[4095], 1);
    chk("full_pc", path_count, 1);
    chk("full_busy_fin", busy, 1'b0);
    step();
    chk("full_done_1cyc", done, 1'b0);
    chk("full_pc_hold", path_count, 1);

    // 3x2 window with a 5-cycle stall on beat 4
    maze_data = '0;
    set_cell(1, 0, 2'b11);
    set_cell(2, 1, 2'b11);
    win_w = 7'd3;
    win_h = 7'd2;
    step();
    kick("win");
    collect(200, 3, 5);
    chk("win_beats", nbeat, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("win_b%0d_x", i + 1), bx[i], exp_x[i]);
      chk($sformatf("win_b%0d_y", i + 1), by[i], exp_y[i]);
      chk($sformatf("win_b%0d_code", i + 1), bc[i], exp_c[i]);
      chk($sformatf("win_b%0d_last", i + 1), bl[i], (i == 5) ? 1 : 0);
    end
    chk("win_b5_after_ready", bcyc[4] - bcyc[3], 1);
    chk("win_pc", path_count, 2);

    // start with maze_done low
    step();
    maze_done = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("err_flag", start_err, 1'b1);
    chk("err_valid", cell_if.cell_valid, 1'b0);
    chk("err_busy", busy, 1'b0);
    step();
    chk("err_sticky", start_err, 1'b1);
    chk("err_valid2", cell_if.cell_valid, 1'b0);
    maze_done = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("err_clear", start_err, 1'b0);
    chk("err_restart_busy", busy, 1'b1);
    step();
    collect(200, -1, 0);
    chk("err_restart_beats", nbeat, 6);
    chk("err_restart_pc", path_count, 2);

    // Abort together with beat 10 handshake in a 64x64 scan
    step();
    maze_data = '0;
    for (int x = 0; x < 10; x++) set_cell(x, 0, 2'b11);
    win_w = 7'd0;
    win_h = 7'd0;
    kick("abort");
    for (int i = 0; i < 9; i++) step();
    chk("abort_b10_x", cell_if.cell_x, 9);
    chk("abort_b10_code", cell_if.cell_code, 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", cell_if.cell_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_pc", path_count, 9);
    step();
    chk("abort_done2", done, 1'b0);
    chk("abort_valid2", cell_if.cell_valid, 1'b0);

    // Async reset at beat 100
    kick("rst");
    for (int i = 0; i < 99; i++) step();
    chk("rst_b100_x", cell_if.cell_x, 35);
    chk("rst_b100_y", cell_if.cell_y, 1);
    chk("rst_b100_pc", path_count, 10);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", cell_if.cell_valid, 1'b0);
    chk("arst_xy", {cell_if.cell_x, cell_if.cell_y}, 12'd0);
    chk("arst_code", cell_if.cell_code, 2'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_pc", path_count, 13'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("arst_idle_valid", cell_if.cell_valid, 1'b0);
      chk("arst_idle_done", done, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maze_reader.md
Name: maze_reader

Overview:
- Reads the packed 2-bit-per-cell maze bitmap produced by the maze carver.
- Once the carver asserts finish, streams cells in raster order (x fastest) over a valid/ready interface to downstream consumers (tile renderer, solver).
- Counts PATH cells in the scanned window.
- Read-only: never modifies maze_data.

Parameters:
- COLS, 64, cells per row
- ROWS, 64, rows
- CELL_W, 2, bits per cell; cell (x,y) occupies maze_data[x*CELL_W + y*COLS*CELL_W +: CELL_W]

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous active-low reset
- maze_data  in  COLS*ROWS*CELL_W (8192)  packed maze bitmap from carver
- maze_done  in  1  carver finish flag; level
- start  in  1  request a scan; sampled in IDLE only
- abort  in  1  synchronous scan cancel
- win_w  in  7  scan window width in cells
- win_h  in  7  scan window height in cells
- cell_valid  out  1  output beat valid
- cell_ready  in  1  downstream accept
- cell_x  out  6  column of current beat
- cell_y  out  6  row of current beat
- cell_code  out  2  cell code: 00 OUT, 01 FRONTIER, 10 WALL, 11 PATH
- cell_solid  out  1  1 when cell_code is 00 or 10 (impassable)
- cell_last  out  1  final beat of window
- busy  out  1  high in LOAD/SCAN
- done  out  1  one-cycle pulse after last beat accepted
- path_count  out  13  PATH beats accepted in the current/last scan
- start_err  out  1  sticky: start seen while maze_done=0

Behaviour:
- Reset (async, reset_n=0): state IDLE; x/y pointers = 0; cell_valid, cell_last, busy, done, start_err = 0; cell_x, cell_y, cell_code, cell_solid = 0; path_count = 0.
- States: IDLE, LOAD, SCAN, FIN.
- IDLE:
  - start=1 and maze_done=1: latch window, clear path_count and start_err, pointers = (0,0), go LOAD.
  - start=1 and maze_done=0: set start_err, stay IDLE.
  - Window clamping at latch: win_w and win_h each clamp to 64 when 0 or greater than 64.
- LOAD: one cycle. Registers cell_x/y/code/solid/last for the pointer, asserts cell_valid, goes to SCAN. First beat is valid 2 cycles after start is sampled.
- SCAN:
  - Outputs hold stable while cell_valid=1 and cell_ready=0.
  - On handshake (valid & ready): path_count increments if cell_code==11.
  - If not last: advance pointer and register the next cell in the same edge, so cell_valid stays 1 and back-to-back ready gives 1 beat/cycle.
  - Pointer advance: x+1; when x==win_w-1, x=0 and y+1.
  - cell_last = (x==win_w-1) and (y==win_h-1).
  - On the last handshake: cell_valid=0, go FIN.
- FIN: done=1 for one cycle, busy=0, go IDLE. path_count holds until the next accepted start.
- busy=1 in LOAD and SCAN only.
- abort=1 in LOAD or SCAN:
  - Next cycle: IDLE, cell_valid=0, no done pulse.
  - abort wins over a simultaneous handshake; that beat is not counted.
  - abort in IDLE or FIN has no effect.
- start while busy: ignored.
- maze_data must remain stable from accepted start until done or abort. maze_done falling mid-scan is ignored.
- cell_code is a pure function of maze_data at the pointer; no arithmetic overflow is possible (path_count max 4096 fits 13 bits).
- Async reset mid-scan forces the full reset state immediately. No done pulse is generated.

Test Plan:
- All cells 00 except (0,0)=11 and (63,63)=10; maze_done=1; win 0x0; ready held 1; pulse start -> 4096 beats on consecutive cycles, first beat 2 cycles after start. Beat 1 is x=0 y=0 code 11 solid 0. Last beat is x=63 y=63 code 10 solid 1 last 1. done pulses 1 cycle after it; path_count=1.
- win_w=3 win_h=2; cells (1,0) and (2,1)=11 -> exactly 6 beats in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1). cell_last only on the 6th; path_count=2.
- Backpressure: hold cell_ready=0 for 5 cycles on beat 4 -> cell_x/y/code stay constant and cell_valid stays 1. Beat 5 follows on the cycle after ready returns; total beat count unchanged.
- start with maze_done=0 -> start_err=1, cell_valid stays 0, busy stays 0. A later start with maze_done=1 clears start_err and starts the scan.
- abort asserted together with the handshake of beat 10 in a 64x64 scan -> cell_valid=0 next cycle, state IDLE, no done pulse, path_count excludes beat 10.
- reset_n low for 1 cycle mid-scan (beat 100) -> all outputs 0 immediately. No further beats until a new start.
